// File: rtl/serdes_lb_pkg.sv
// serdes_lb_pkg
// Shared constants and helpers for the SERDES loopback traffic generator/checker.
//   K28_5      : comma character (sent with K=1 in byte 0 of each frame's first word)
//   D10_2      : idle/filler data character
//   PRBS7_SEED : LFSR value loaded at every comma
//   lb_state_e : checker lock FSM states
//   prbs7_step : one step of the x^7+x^6+1 LFSR; the new LSB is the generated bit
package serdes_lb_pkg;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [7:0] D10_2      = 8'h4A;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } lb_state_e;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/serdes_lb_patgen.sv
// serdes_lb_patgen
// Frame/pattern generator. Produces one registered word per cycle:
// a comma word at frame index 0, then COMMA_PERIOD-1 data words
// (byte counter or PRBS-7). Used both as TX source and as RX expected model.
// Ports:
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_en          : generate traffic; when low an idle word is sent and the index returns to 0
//   i_restart     : force the next word to be a comma (frame restart)
//   i_inj         : request a single-bit error in the next data word (pending until used)
//   o_data        : generated word, byte 0 in bits [7:0]
//   o_charisk     : per-byte K flags
module serdes_lb_patgen #(
  parameter int BYTES        = 8,
  parameter int COMMA_PERIOD = 16,
  parameter int PATTERN      = 0
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_en,
  input  logic               i_restart,
  input  logic               i_inj,
  output logic [8*BYTES-1:0] o_data,
  output logic [BYTES-1:0]   o_charisk
);
  import serdes_lb_pkg::*;

  localparam int W     = 8 * BYTES;
  localparam int IDX_W = $clog2(COMMA_PERIOD);

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_seq;
  logic [6:0]       r_lfsr;
  logic             r_injPend;

  logic [W-1:0]     w_word;
  logic [BYTES-1:0] w_k;
  logic [IDX_W-1:0] w_nextIdx;
  logic [7:0]       w_nextSeq;
  logic [6:0]       w_nextLfsr;
  logic [6:0]       w_s;
  logic             w_active;
  logic             w_comma;
  logic             w_injNow;
  logic             w_injUsed;

  // Word for the current frame index; a restart behaves exactly like index 0.
  always_comb begin
    w_active   = i_en | i_restart;
    w_comma    = i_restart | (r_idx == '0);
    w_injNow   = r_injPend | i_inj;
    w_injUsed  = 1'b0;
    w_word     = {BYTES{D10_2}};
    w_k        = '0;
    w_nextIdx  = '0;
    w_nextSeq  = r_seq;
    w_nextLfsr = r_lfsr;
    w_s        = r_lfsr;
    if (w_active && w_comma) begin
      w_word[7:0] = K28_5;
      w_k[0]      = 1'b1;
      w_nextIdx   = IDX_W'(1);
      w_nextSeq   = '0;
      w_nextLfsr  = PRBS7_SEED;
    end else if (w_active) begin
      if (PATTERN == 0) begin
        for (int k = 0; k < BYTES; k++) begin
          w_word[8*k +: 8] = r_seq + 8'(k);
        end
        w_nextSeq = r_seq + 8'(BYTES);
      end else begin
        // Bit 0 of the word is the first bit out of the LFSR.
        for (int b = 0; b < W; b++) begin
          w_s       = prbs7_step(w_s);
          w_word[b] = w_s[0];
        end
        w_nextLfsr = w_s;
      end
      if (w_injNow) begin
        w_word[0] = ~w_word[0];
        w_injUsed = 1'b1;
      end
      w_nextIdx = (r_idx == IDX_W'(COMMA_PERIOD - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // Registered output and frame state; injection requests collapse until a data word takes them.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_idx     <= '0;
      r_seq     <= '0;
      r_lfsr    <= PRBS7_SEED;
      r_injPend <= 1'b0;
      o_data    <= '0;
      o_charisk <= '0;
    end else begin
      r_idx     <= w_nextIdx;
      r_seq     <= w_nextSeq;
      r_lfsr    <= w_nextLfsr;
      r_injPend <= w_injNow & ~w_injUsed;
      o_data    <= w_word;
      o_charisk <= w_k;
    end
  end

endmodule

// File: rtl/serdes_lb_trafgen.sv
// serdes_lb_trafgen
// Loopback traffic generator and checker for the SERDES link test.
// TX: periodic K28.5 comma word followed by counter or PRBS-7 data words.
// RX: byte-lane realignment on the comma, compare against a local model,
// lock FSM (SEARCH/SYNC/LOCKED), saturating error and wrapping word counters.
// Optional feature macro: SERDES_LB_ERR_INJECT_EN adds inj_err_i.
// Ports:
//   ref_clk, rstn_i        : clock, synchronous active-low reset
//   en_i                   : enable traffic generation
//   cnt_clr_i              : clear error/word counters (wins over increment)
//   inj_err_i              : (macro only) flip bit 0 of the next TX data word
//   tx_data_o/tx_charisk_o : registered TX word and K flags
//   rx_data_i/rx_charisk_i/rx_notintable_i : returned RX word, K flags, code violations
//   locked_o, comma_pos_o  : lock status, lane in which the comma was found
//   err_o, err_cnt_o, word_cnt_o : error pulse, saturating error count, checked-word count
module serdes_lb_trafgen #(
  parameter int BYTES        = 8,
  parameter int COMMA_PERIOD = 16,
  parameter int PATTERN      = 0,
  parameter int LOCK_CNT     = 4,
  parameter int LOSS_CNT     = 4,
  parameter int ERR_CNT_W    = 32
) (
  input  logic                 ref_clk,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 cnt_clr_i,
`ifdef SERDES_LB_ERR_INJECT_EN
  input  logic                 inj_err_i,
`endif
  output logic [8*BYTES-1:0]   tx_data_o,
  output logic [BYTES-1:0]     tx_charisk_o,
  input  logic [8*BYTES-1:0]   rx_data_i,
  input  logic [BYTES-1:0]     rx_charisk_i,
  input  logic [BYTES-1:0]     rx_notintable_i,
  output logic                 locked_o,
  output logic [2:0]           comma_pos_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [31:0]          word_cnt_o
);
  import serdes_lb_pkg::*;

  localparam int W      = 8 * BYTES;
  localparam int FW_W   = $clog2(COMMA_PERIOD);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);

  lb_state_e         r_state;
  lb_state_e         w_nextState;
  logic [W-1:0]      r_prevData;
  logic [BYTES-1:0]  r_prevK;
  logic [BYTES-1:0]  r_prevNit;
  logic [2:0]        r_pos;
  logic              r_err;
  logic [ERR_CNT_W-1:0] r_errCnt;
  logic [31:0]       r_wordCnt;
  logic [FW_W-1:0]   r_frameWords;
  logic [LOCK_W-1:0] r_frames;
  logic [LOSS_W-1:0] r_loss;

  logic [2*W-1:0]     w_catData;
  logic [2*BYTES-1:0] w_catK;
  logic [2*BYTES-1:0] w_catNit;
  logic [W-1:0]       w_alData;
  logic [BYTES-1:0]   w_alK;
  logic [BYTES-1:0]   w_alNit;
  logic [W-1:0]       w_expData;
  logic [BYTES-1:0]   w_expK;
  logic               w_inj;
  logic               w_hit;
  logic [2:0]         w_hitLane;
  logic               w_mismatch;
  logic               w_restart;
  logic               w_frameEnd;
  logic               w_lockedErr;

`ifdef SERDES_LB_ERR_INJECT_EN
  assign w_inj = inj_err_i;
`else
  assign w_inj = 1'b0;
`endif

  serdes_lb_patgen #(.BYTES(BYTES), .COMMA_PERIOD(COMMA_PERIOD), .PATTERN(PATTERN)) u_txGen (
    .i_clk     (ref_clk),
    .i_rstn    (rstn_i),
    .i_en      (en_i),
    .i_restart (1'b0),
    .i_inj     (w_inj),
    .o_data    (tx_data_o),
    .o_charisk (tx_charisk_o)
  );

  // Expected-pattern model: restarted on the comma, then advances once per compared word.
  serdes_lb_patgen #(.BYTES(BYTES), .COMMA_PERIOD(COMMA_PERIOD), .PATTERN(PATTERN)) u_rxModel (
    .i_clk     (ref_clk),
    .i_rstn    (rstn_i),
    .i_en      (r_state != ST_SEARCH),
    .i_restart (w_restart),
    .i_inj     (1'b0),
    .o_data    (w_expData),
    .o_charisk (w_expK)
  );

  // The comma lane found in word N puts the aligned word across words N and N+1,
  // so the aligned word is taken from {current, previous}.
  always_comb begin
    w_catData  = {rx_data_i, r_prevData};
    w_catK     = {rx_charisk_i, r_prevK};
    w_catNit   = {rx_notintable_i, r_prevNit};
    w_alData   = w_catData[{r_pos, 3'b000} +: W];
    w_alK      = w_catK[r_pos +: BYTES];
    w_alNit    = w_catNit[r_pos +: BYTES];
    w_mismatch = (w_alData != w_expData) || (w_alK != w_expK) || (w_alNit != '0);
    w_frameEnd = (r_frameWords == FW_W'(COMMA_PERIOD - 1));
    w_lockedErr = (r_state == ST_LOCKED) && w_mismatch;
  end

  // Comma search on the raw word; iterating downward leaves the lowest matching lane.
  always_comb begin
    w_hit     = 1'b0;
    w_hitLane = '0;
    for (int j = BYTES - 1; j >= 0; j--) begin
      if (rx_charisk_i[j] && (rx_data_i[8*j +: 8] == K28_5)) begin
        w_hit     = 1'b1;
        w_hitLane = 3'(j);
      end
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rstn_i) r_state <= ST_SEARCH;
    else         r_state <= w_nextState;
  end

  // Lock FSM next-state logic.
  always_comb begin
    w_nextState = r_state;
    w_restart   = 1'b0;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_hit) begin
          w_nextState = ST_SYNC;
          w_restart   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (w_mismatch)
          w_nextState = ST_SEARCH;
        else if (w_frameEnd && (r_frames == LOCK_W'(LOCK_CNT - 1)))
          w_nextState = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (w_mismatch && (r_loss == LOSS_W'(LOSS_CNT - 1)))
          w_nextState = ST_SEARCH;
      end
      default: w_nextState = ST_SEARCH;
    endcase
  end

  // RX history, frame/loss run counters and the user-visible counters.
  always_ff @(posedge ref_clk) begin
    if (!rstn_i) begin
      r_prevData   <= '0;
      r_prevK      <= '0;
      r_prevNit    <= '0;
      r_pos        <= '0;
      r_err        <= 1'b0;
      r_errCnt     <= '0;
      r_wordCnt    <= '0;
      r_frameWords <= '0;
      r_frames     <= '0;
      r_loss       <= '0;
    end else begin
      r_prevData <= rx_data_i;
      r_prevK    <= rx_charisk_i;
      r_prevNit  <= rx_notintable_i;
      if (w_restart) r_pos <= w_hitLane;
      if ((r_state == ST_SYNC) && !w_mismatch) begin
        if (w_frameEnd) begin
          r_frameWords <= '0;
          r_frames     <= r_frames + LOCK_W'(1);
        end else begin
          r_frameWords <= r_frameWords + FW_W'(1);
        end
      end else begin
        r_frameWords <= '0;
        r_frames     <= '0;
      end
      r_loss <= w_lockedErr ? r_loss + LOSS_W'(1) : '0;
      r_err  <= w_lockedErr;
      if (cnt_clr_i)
        r_errCnt <= '0;
      else if (w_lockedErr && (r_errCnt != '1))
        r_errCnt <= r_errCnt + ERR_CNT_W'(1);
      if (cnt_clr_i)
        r_wordCnt <= '0;
      else if (r_state == ST_LOCKED)
        r_wordCnt <= r_wordCnt + 32'd1;
    end
  end

  assign locked_o    = (r_state == ST_LOCKED);
  assign comma_pos_o = r_pos;
  assign err_o       = r_err;
  assign err_cnt_o   = r_errCnt;
  assign word_cnt_o  = r_wordCnt;

endmodule

// File: tb/tb_serdes_lb_trafgen.sv
// tb_serdes_lb_trafgen
// Directed bench: dutA (counter pattern, 32-bit error counter) looped back with
// a selectable byte offset, dutB (PRBS-7, 4-bit error counter) looped back with
// a fixed 3-byte offset. Both share clock, reset, enable and counter clear.
module tb_serdes_lb_trafgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, en, cntClr;
  int   checks = 0;
  int   failures = 0;
  logic ok;

  logic [63:0] txDataA, rxDataA, txPrevA, corrA;
  logic [7:0]  txKA, rxKA, txKPrevA;
  int          offA;
  logic        lockedA, errA;
  logic [2:0]  posA;
  logic [31:0] errCntA, wordCntA;

  logic [63:0] txDataB, rxDataB, txPrevB, corrB;
  logic [7:0]  txKB, rxKB, txKPrevB;
  logic        lockedB, errB;
  logic [2:0]  posB;
  logic [3:0]  errCntB;
  logic [31:0] wordCntB;

  // Delay the TX stream by 'off' bytes across word boundaries.
  function automatic logic [63:0] delayBytes(input logic [63:0] cur, input logic [63:0] prev, input int off);
    logic [127:0] c;
    c = {cur, prev};
    c = c >> (64 - 8 * off);
    return c[63:0];
  endfunction

  function automatic logic [7:0] delayK(input logic [7:0] cur, input logic [7:0] prev, input int off);
    logic [15:0] c;
    c = {cur, prev};
    c = c >> (8 - off);
    return c[7:0];
  endfunction

  // First PRBS-7 data word after a comma: seed 7F, x^7+x^6+1, first bit in bit 0.
  function automatic logic [63:0] prbsFirstWord();
    logic [6:0]  s;
    logic [63:0] w;
    logic        nb;
    s = 7'h7F;
    w = '0;
    for (int b = 0; b < 64; b++) begin
      nb   = s[6] ^ s[5];
      w[b] = nb;
      s    = {s[5:0], nb};
    end
    return w;
  endfunction

  always @(posedge clk) begin
    txPrevA  <= txDataA;
    txKPrevA <= txKA;
    txPrevB  <= txDataB;
    txKPrevB <= txKB;
  end

  assign rxDataA = delayBytes(txDataA, txPrevA, offA) ^ corrA;
  assign rxKA    = delayK(txKA, txKPrevA, offA);
  assign rxDataB = delayBytes(txDataB, txPrevB, 3) ^ corrB;
  assign rxKB    = delayK(txKB, txKPrevB, 3);

  serdes_lb_trafgen #(.BYTES(8), .COMMA_PERIOD(16), .PATTERN(0), .LOCK_CNT(4),
                      .LOSS_CNT(4), .ERR_CNT_W(32)) dutA (
    .ref_clk         (clk),
    .rstn_i          (rstn),
    .en_i            (en),
    .cnt_clr_i       (cntClr),
    .tx_data_o       (txDataA),
    .tx_charisk_o    (txKA),
    .rx_data_i       (rxDataA),
    .rx_charisk_i    (rxKA),
    .rx_notintable_i (8'h00),
    .locked_o        (lockedA),
    .comma_pos_o     (posA),
    .err_o           (errA),
    .err_cnt_o       (errCntA),
    .word_cnt_o      (wordCntA)
  );

  serdes_lb_trafgen #(.BYTES(8), .COMMA_PERIOD(16), .PATTERN(1), .LOCK_CNT(4),
                      .LOSS_CNT(4), .ERR_CNT_W(4)) dutB (
    .ref_clk         (clk),
    .rstn_i          (rstn),
    .en_i            (en),
    .cnt_clr_i       (cntClr),
    .tx_data_o       (txDataB),
    .tx_charisk_o    (txKB),
    .rx_data_i       (rxDataB),
    .rx_charisk_i    (rxKB),
    .rx_notintable_i (8'h00),
    .locked_o        (lockedB),
    .comma_pos_o     (posB),
    .err_o           (errB),
    .err_cnt_o       (errCntB),
    .word_cnt_o      (wordCntB)
  );

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rstn   = 1'b0;
    en     = 1'b0;
    cntClr = 1'b0;
    corrA  = '0;
    corrB  = '0;
    offA   = 0;
    applyStimulus(3);

    $display("[TB] reset state");
    checkOutput("rst_txA",     txDataA,  64'h0);
    checkOutput("rst_kA",      txKA,     64'h0);
    checkOutput("rst_lockA",   lockedA,  64'h0);
    checkOutput("rst_posA",    posA,     64'h0);
    checkOutput("rst_errA",    errA,     64'h0);
    checkOutput("rst_errCntA", errCntA,  64'h0);
    checkOutput("rst_wcA",     wordCntA, 64'h0);
    checkOutput("rst_txB",     txDataB,  64'h0);

    $display("[TB] TX pattern");
    rstn = 1'b1;
    en   = 1'b1;
    applyStimulus(1);
    checkOutput("tx_comma",    txDataA, 64'h4A4A4A4A_4A4A4ABC);
    checkOutput("tx_commaK",   txKA,    64'h01);
    checkOutput("txB_comma",   txDataB, 64'h4A4A4A4A_4A4A4ABC);
    applyStimulus(1);
    checkOutput("tx_data1",    txDataA, 64'h07060504_03020100);
    checkOutput("tx_data1K",   txKA,    64'h00);
    checkOutput("txB_prbs1",   txDataB, prbsFirstWord());
    applyStimulus(1);
    checkOutput("tx_data2",    txDataA, 64'h0F0E0D0C_0B0A0908);
    applyStimulus(14);
    checkOutput("tx_comma2",   txDataA, 64'h4A4A4A4A_4A4A4ABC);
    checkOutput("tx_comma2K",  txKA,    64'h01);

    $display("[TB] loopback lock");
    applyStimulus(43);
    checkOutput("early_lockA", lockedA, 64'h0);
    checkOutput("early_lockB", lockedB, 64'h0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      applyStimulus(1);
      ok = lockedA;
    end
    checkOutput("lockA_reached", ok, 64'h1);
    checkOutput("lockB_reached", lockedB, 64'h1);
    checkOutput("posA",          posA,    64'h0);
    checkOutput("posB",          posB,    64'h3);
    checkOutput("errCntB_clean", errCntB, 64'h0);
    applyStimulus(10);
    checkOutput("wordCntA_10",   wordCntA, 64'd10);
    checkOutput("errCntA_clean", errCntA,  64'h0);

    $display("[TB] single bit error");
    corrA = 64'h100;
    applyStimulus(1);
    corrA = '0;
    applyStimulus(1);
    checkOutput("err1_pulse", errA,    64'h1);
    checkOutput("err1_cnt",   errCntA, 64'h1);
    applyStimulus(1);
    checkOutput("err1_pulse_end", errA,    64'h0);
    checkOutput("err1_locked",    lockedA, 64'h1);
    checkOutput("err1_cnt_hold",  errCntA, 64'h1);

    $display("[TB] loss of lock");
    cntClr = 1'b1;
    applyStimulus(1);
    cntClr = 1'b0;
    checkOutput("clr_errCnt",  errCntA,  64'h0);
    checkOutput("clr_wordCnt", wordCntA, 64'h0);
    corrA = 64'h100;
    applyStimulus(4);
    corrA = '0;
    applyStimulus(2);
    checkOutput("loss_errCnt", errCntA, 64'h4);
    checkOutput("loss_lock",   lockedA, 64'h0);
    ok = 1'b0;
    for (int i = 0; i < 120 && !ok; i++) begin
      applyStimulus(1);
      ok = lockedA;
    end
    checkOutput("relockA", ok, 64'h1);

    $display("[TB] clear versus error");
    corrA = 64'h100;
    applyStimulus(1);
    corrA  = '0;
    cntClr = 1'b1;
    applyStimulus(1);
    cntClr = 1'b0;
    checkOutput("clrerr_pulse", errA,    64'h1);
    checkOutput("clrerr_cnt",   errCntA, 64'h0);

    $display("[TB] saturation");
    for (int i = 0; i < 20; i++) begin
      corrB = 64'h1_0000_0000;
      applyStimulus(1);
      corrB = '0;
      applyStimulus(1);
    end
    checkOutput("sat_errCntB", errCntB, 64'hF);
    checkOutput("sat_lockB",   lockedB, 64'h1);

    $display("[TB] realign to lane 3");
    offA = 3;
    ok = 1'b1;
    for (int i = 0; i < 20 && ok; i++) begin
      applyStimulus(1);
      ok = lockedA;
    end
    checkOutput("shift_drop", ok, 64'h0);
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      applyStimulus(1);
      ok = lockedA;
    end
    checkOutput("shift_relock", ok,   64'h1);
    checkOutput("shift_posA",   posA, 64'h3);
    cntClr = 1'b1;
    applyStimulus(1);
    cntClr = 1'b0;
    applyStimulus(20);
    checkOutput("shift_errCnt", errCntA, 64'h0);
    checkOutput("shift_locked", lockedA, 64'h1);

    $display("[TB] reset mid-frame");
    rstn = 1'b0;
    applyStimulus(1);
    checkOutput("mid_txA",     txDataA,  64'h0);
    checkOutput("mid_kA",      txKA,     64'h0);
    checkOutput("mid_lockA",   lockedA,  64'h0);
    checkOutput("mid_posA",    posA,     64'h0);
    checkOutput("mid_errA",    errA,     64'h0);
    checkOutput("mid_errCntA", errCntA,  64'h0);
    checkOutput("mid_wcA",     wordCntA, 64'h0);
    rstn = 1'b1;
    applyStimulus(1);
    checkOutput("post_comma",  txDataA, 64'h4A4A4A4A_4A4A4ABC);
    checkOutput("post_commaK", txKA,    64'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
